alarme_ctrl: RTL

- Sequential, parametrised successor to the combinational four-input alarm: N sensor zones, per-zone mask, arm/disarm control, exit and entry delays, timed siren, latched zone memory.
- Sits between synchronised sensor inputs and siren/indicator drivers.
- Single clock domain; all inputs arrive already synchronised to clk.

---
 rtl/alarme_pkg.sv | 31 +++
 rtl/alarme_temporizador.sv | 28 ++
 rtl/alarme_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alarme_pkg.sv
// Shared types and helpers for the alarme_ctrl slice.
// TAMPER (6) is only reachable when ALARME_TAMPER_EN is defined.
package alarme_pkg;

  localparam int ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    DESARMADO  = 3'd0,
    SAIDA      = 3'd1,
    ARMADO     = 3'd2,
    ENTRADA    = 3'd3,
    DISPARADO  = 3'd4,
    SILENCIADO = 3'd5,
    TAMPER     = 3'd6
  } estado_t;

  // Width needed to hold the largest of the three timer reloads.
  function automatic int cnt_w(
    input int t_saida,
    input int t_entrada,
    input int t_sirene
  );
    int m;
    m = t_saida;
    if (t_entrada > m) m = t_entrada;
    if (t_sirene > m) m = t_sirene;
    if (m < 1) return 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alarme_temporizador.sv
// Loadable down-counter shared by the exit, entry and siren timing.
// Saturates at zero; load has priority over decrement.
module alarme_temporizador #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carregar,
  input  logic         decrementar,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (carregar) begin
      cnt <= valor;
    end else if (decrementar && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alarme_ctrl.sv
// Sequential N-zone alarm controller with exit/entry delays and timed siren.
// Define ALARME_TAMPER_EN to add the tamper input and TAMPER state.
module alarme_ctrl #(
  parameter int N_ZONAS   = 4,
  parameter int T_SAIDA   = 8,
  parameter int T_ENTRADA = 8,
  parameter int T_SIRENE  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               armar,
  input  logic               desarmar,
`ifdef ALARME_TAMPER_EN
  input  logic               tamper,
`endif
  input  logic [N_ZONAS-1:0] sensores,
  input  logic [N_ZONAS-1:0] mascara,
  output logic               sirene,
  output logic               armado,
  output logic               pendente,
  output logic               falha_arm,
  output logic [N_ZONAS-1:0] memoria,
  output logic [2:0]         estado
);

  import alarme_pkg::*;

  localparam int CW = cnt_w(T_SAIDA, T_ENTRADA, T_SIRENE);

  localparam logic [2:0] S_DES  = DESARMADO;
  localparam logic [2:0] S_SAI  = SAIDA;
  localparam logic [2:0] S_ARM  = ARMADO;
  localparam logic [2:0] S_ENT  = ENTRADA;
  localparam logic [2:0] S_DISP = DISPARADO;
  localparam logic [2:0] S_SIL  = SILENCIADO;
`ifdef ALARME_TAMPER_EN
  localparam logic [2:0] S_TAMP = TAMPER;
`endif

  localparam logic [CW-1:0] V_SAI = CW'(T_SAIDA - 1);
  localparam logic [CW-1:0] V_ENT = CW'(T_ENTRADA - 1);
  localparam logic [CW-1:0] V_SIR = CW'(T_SIRENE - 1);

  localparam logic [N_ZONAS-1:0] ZONA0 = N_ZONAS'(1);

  logic [N_ZONAS-1:0] ativo;
  logic               inst;
  logic               novo;
  logic               zero;

  logic               carregar;
  logic               decrementar;
  logic [CW-1:0]      valor;

  logic [2:0]         estado_n;
  logic [N_ZONAS-1:0] memoria_n;
  logic               falha_n;
  logic               sirene_n;

  assign ativo = sensores & mascara;
  assign inst  = |(ativo & ~ZONA0);
  assign novo  = |(ativo & ~memoria);

  always_comb begin
    estado_n    = estado;
    memoria_n   = memoria;
    falha_n     = 1'b0;
    carregar    = 1'b0;
    decrementar = 1'b0;
    valor       = '0;

    if (desarmar) begin
      estado_n = S_DES;
      carregar = 1'b1;
    end else begin
      unique case (estado)
        S_DES: begin
          if (armar) begin
            if (ativo == '0) begin
              estado_n  = S_SAI;
              carregar  = 1'b1;
              valor     = V_SAI;
              memoria_n = '0;
            end else begin
              falha_n = 1'b1;
            end
          end
        end
        S_SAI: begin
          if (zero) estado_n = S_ARM;
          else decrementar = 1'b1;
        end
        S_ARM: begin
          if (inst) begin
            estado_n  = S_DISP;
            carregar  = 1'b1;
            valor     = V_SIR;
            memoria_n = memoria | ativo;
          end else if (ativo[0]) begin
            estado_n     = S_ENT;
            carregar     = 1'b1;
            valor        = V_ENT;
            memoria_n[0] = 1'b1;
          end
        end
        S_ENT: begin
          if (inst) begin
            estado_n  = S_DISP;
            carregar  = 1'b1;
            valor     = V_SIR;
            memoria_n = memoria | ativo;
          end else if (zero) begin
            estado_n = S_DISP;
            carregar = 1'b1;
            valor    = V_SIR;
          end else begin
            decrementar = 1'b1;
          end
        end
        S_DISP: begin
          memoria_n = memoria | ativo;
          if (zero) estado_n = S_SIL;
          else decrementar = 1'b1;
        end
        S_SIL: begin
          // Only zones not yet latched may restart the siren.
          if (novo) begin
            estado_n  = S_DISP;
            carregar  = 1'b1;
            valor     = V_SIR;
            memoria_n = memoria | ativo;
          end
        end
        default: begin
          estado_n = S_DES;
          carregar = 1'b1;
        end
      endcase
    end

    sirene_n = (estado_n == S_DISP);

`ifdef ALARME_TAMPER_EN
    // Tamper overrides everything, including disarm.
    if (estado == S_TAMP || tamper) begin
      memoria_n   = memoria;
      falha_n     = 1'b0;
      carregar    = 1'b1;
      decrementar = 1'b0;
      valor       = '0;
      sirene_n    = tamper;
      if (estado == S_TAMP && !tamper && desarmar)
        estado_n = S_DES;
      else
        estado_n = S_TAMP;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= S_DES;
      memoria   <= '0;
      sirene    <= 1'b0;
      falha_arm <= 1'b0;
    end else begin
      estado    <= estado_n;
      memoria   <= memoria_n;
      sirene    <= sirene_n;
      falha_arm <= falha_n;
    end
  end

  assign armado   = estado inside {S_SAI, S_ARM, S_ENT, S_DISP, S_SIL};
  assign pendente = estado inside {S_SAI, S_ENT};

  alarme_temporizador #(
    .W(CW)
  ) u_temp (
    .clk        (clk),
    .rst        (rst),
    .carregar   (carregar),
    .decrementar(decrementar),
    .valor      (valor),
    .zero       (zero)
  );

endmodule
